// File: rtl/paddle_pkg.sv
// Shared types for the paddle motion scheduler.
//   pstate_e : per-player acceleration FSM state
//   seq_e    : frame sequencer state
//   cmd_e    : resolved per-player button command
//   BTN_*    : bit positions within btn_raw {p2_down,p2_up,p1_down,p1_up}
//   DIR_*    : direction encoding on dir1/dir2
package paddle_pkg;

    typedef enum logic [1:0] {IDLE, SLOW, FAST} pstate_e;
    typedef enum logic [1:0] {S_IDLE, S_P1, S_P2} seq_e;
    typedef enum logic [1:0] {NONE, UP, DOWN} cmd_e;

    localparam int BTN_P1_UP = 0;
    localparam int BTN_P1_DN = 1;
    localparam int BTN_P2_UP = 2;
    localparam int BTN_P2_DN = 3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Up and down held together cancel out.
    function automatic cmd_e decode_cmd(input logic up, input logic dn);
        cmd_e c;
        c = NONE;
        if (up && !dn) c = UP;
        if (dn && !up) c = DOWN;
        return c;
    endfunction

endpackage

// File: rtl/paddle_motion_sched_if.sv
// Update-strobe bundle from the motion scheduler to the position datapath.
//   upd1/dir1/step1 : player 1 strobe, direction (0 up, 1 down), step size
//   upd2/dir2/step2 : player 2 strobe, direction, step size
//   busy            : sequencer is mid-frame
//   master : scheduler side (drives)   slave : datapath side (receives)
interface paddle_motion_sched_if #(
    parameter int STEP_W = 4
);
    logic              upd1;
    logic              dir1;
    logic [STEP_W-1:0] step1;
    logic              upd2;
    logic              dir2;
    logic [STEP_W-1:0] step2;
    logic              busy;

    modport master (output upd1, dir1, step1, upd2, dir2, step2, busy);
    modport slave  (input  upd1, dir1, step1, upd2, dir2, step2, busy);
endinterface

// File: rtl/btn_debounce.sv
// Single-button synchroniser and debouncer.
//   clk, rst : system clock, synchronous active-high reset
//   i_raw    : asynchronous raw button level
//   o_deb    : debounced level; follows the synchronised input once it has
//              disagreed with o_deb for 2**DEB_BITS consecutive clocks
module btn_debounce #(
    parameter int DEB_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_deb
);

    logic                r_s1;
    logic                r_s2;
    logic                r_deb;
    logic [DEB_BITS-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == '1) begin
                // This is the 2**DEB_BITS-th consecutive disagreeing clock.
                r_deb <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/paddle_motion_sched.sv
// Per-frame paddle motion controller.
//   clk, rst   : system clock, synchronous active-high reset
//   frame_tick : one-clock pulse per video frame
//   freeze     : pause; no motion, both player FSMs forced to IDLE
//   btn_raw    : {p2_down,p2_up,p1_down,p1_up}, asynchronous, active-high
//   mo         : update strobes, direction, step size and busy (master side)
// Each frame the sequencer walks S_P1 then S_P2, evaluating one player per
// clock so the downstream position datapath can share one adder/clamp.
module paddle_motion_sched
    import paddle_pkg::*;
#(
    parameter int DEB_BITS    = 16,
    parameter int STEP_SLOW   = 1,
    parameter int STEP_FAST   = 4,
    parameter int HOLD_FRAMES = 8,
    parameter int STEP_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       freeze,
    input  logic [3:0] btn_raw,
    paddle_motion_sched_if.master mo
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0]     HOLD_MAX = HW'(HOLD_FRAMES);
    localparam logic [STEP_W-1:0] W_SLOW   = STEP_W'(STEP_SLOW);
    localparam logic [STEP_W-1:0] W_FAST   = STEP_W'(STEP_FAST);

    typedef struct packed {
        pstate_e           st;
        logic [HW-1:0]     hold;
        logic              dir;
        logic              strobe;
        logic [STEP_W-1:0] step;
    } peval_t;

    // Next player state plus strobe for one frame evaluation.
    function automatic peval_t player_eval(
        input pstate_e       st,
        input logic [HW-1:0] hold,
        input logic          last_dir,
        input cmd_e          cmd,
        input logic          frz
    );
        peval_t        r;
        logic          cdir;
        logic [HW-1:0] hold_n;
        cdir     = (cmd == DOWN) ? DIR_DOWN : DIR_UP;
        hold_n   = (hold == HOLD_MAX) ? hold : hold + HW'(1);
        r.st     = st;
        r.hold   = hold;
        r.dir    = last_dir;
        r.strobe = 1'b0;
        r.step   = W_SLOW;
        if (frz || cmd == NONE) begin
            r.st   = IDLE;
            r.hold = '0;
        end else begin
            r.strobe = 1'b1;
            if (st == IDLE || cdir != last_dir) begin
                r.st   = SLOW;
                r.hold = '0;
                r.dir  = cdir;
                r.step = W_SLOW;
            end else if (st == SLOW) begin
                r.hold = hold_n;
                if (hold_n >= HOLD_MAX) begin
                    r.st   = FAST;
                    r.step = W_FAST;
                end else begin
                    r.st   = SLOW;
                    r.step = W_SLOW;
                end
            end else begin
                r.st   = FAST;
                r.step = W_FAST;
            end
        end
        return r;
    endfunction

    logic [3:0] w_deb;
    cmd_e       w_cmd1;
    cmd_e       w_cmd2;
    peval_t     w_ev1;
    peval_t     w_ev2;

    seq_e          r_seq;
    pstate_e       r_st1;
    pstate_e       r_st2;
    logic [HW-1:0] r_hold1;
    logic [HW-1:0] r_hold2;
    logic          r_last1;
    logic          r_last2;

    logic              r_upd1;
    logic              r_dir1;
    logic [STEP_W-1:0] r_step1;
    logic              r_upd2;
    logic              r_dir2;
    logic [STEP_W-1:0] r_step2;
    logic              r_busy;

    for (genvar g = 0; g < 4; g++) begin : g_deb
        btn_debounce #(
            .DEB_BITS(DEB_BITS)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .i_raw (btn_raw[g]),
            .o_deb (w_deb[g])
        );
    end

    always_comb begin
        w_cmd1 = decode_cmd(w_deb[BTN_P1_UP], w_deb[BTN_P1_DN]);
        w_cmd2 = decode_cmd(w_deb[BTN_P2_UP], w_deb[BTN_P2_DN]);
        w_ev1  = player_eval(r_st1, r_hold1, r_last1, w_cmd1, freeze);
        w_ev2  = player_eval(r_st2, r_hold2, r_last2, w_cmd2, freeze);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq   <= S_IDLE;
            r_st1   <= IDLE;
            r_st2   <= IDLE;
            r_hold1 <= '0;
            r_hold2 <= '0;
            r_last1 <= 1'b0;
            r_last2 <= 1'b0;
            r_upd1  <= 1'b0;
            r_dir1  <= 1'b0;
            r_step1 <= '0;
            r_upd2  <= 1'b0;
            r_dir2  <= 1'b0;
            r_step2 <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_upd1 <= 1'b0;
            r_upd2 <= 1'b0;
            unique case (r_seq)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_seq  <= S_P1;
                        r_busy <= 1'b1;
                    end
                end
                S_P1: begin
                    r_st1   <= w_ev1.st;
                    r_hold1 <= w_ev1.hold;
                    r_last1 <= w_ev1.dir;
                    r_upd1  <= w_ev1.strobe;
                    if (w_ev1.strobe) begin
                        r_dir1  <= w_ev1.dir;
                        r_step1 <= w_ev1.step;
                    end
                    r_seq  <= S_P2;
                    r_busy <= 1'b1;
                end
                S_P2: begin
                    r_st2   <= w_ev2.st;
                    r_hold2 <= w_ev2.hold;
                    r_last2 <= w_ev2.dir;
                    r_upd2  <= w_ev2.strobe;
                    if (w_ev2.strobe) begin
                        r_dir2  <= w_ev2.dir;
                        r_step2 <= w_ev2.step;
                    end
                    r_seq  <= S_IDLE;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_seq  <= S_IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign mo.upd1  = r_upd1;
    assign mo.dir1  = r_dir1;
    assign mo.step1 = r_step1;
    assign mo.upd2  = r_upd2;
    assign mo.dir2  = r_dir2;
    assign mo.step2 = r_step2;
    assign mo.busy  = r_busy;

endmodule

// File: tb/tb_paddle_motion_sched.sv
// Directed bench for paddle_motion_sched with DEB_BITS=2, HOLD_FRAMES=3,
// STEP_SLOW=1, STEP_FAST=4. Inputs are driven and outputs sampled on the
// falling edge.
module tb_paddle_motion_sched;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       freeze;
    logic [3:0] btn_raw;

    paddle_motion_sched_if #(.STEP_W(4)) pif ();

    paddle_motion_sched #(
        .DEB_BITS    (2),
        .STEP_SLOW   (1),
        .STEP_FAST   (4),
        .HOLD_FRAMES (3),
        .STEP_W      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .freeze     (freeze),
        .btn_raw    (btn_raw),
        .mo         (pif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observations from the last frame window.
    int n1, n2, at1, at2, d1, s1, d2, s2, both, b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise frame_tick for tick_len clocks, then watch 8 sample points.
    // Sample i is taken on the falling edge after the (i+1)-th rising edge
    // that saw the first tick, so upd1 is expected at i=1 and upd2 at i=2.
    task automatic do_frame(input int tick_len);
        n1 = 0; n2 = 0; at1 = -1; at2 = -1;
        d1 = -1; s1 = -1; d2 = -1; s2 = -1; both = 0; b0 = 0;
        frame_tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == tick_len - 1) frame_tick = 1'b0;
            if (i == 0) b0 = int'(pif.busy);
            if (pif.upd1) begin
                n1++; at1 = i; d1 = int'(pif.dir1); s1 = int'(pif.step1);
            end
            if (pif.upd2) begin
                n2++; at2 = i; d2 = int'(pif.dir2); s2 = int'(pif.step2);
            end
            if (pif.upd1 && pif.upd2) both++;
        end
    endtask

    int exp_down[5] = '{1, 1, 1, 4, 4};
    int exp_up[4]   = '{1, 1, 1, 4};

    initial begin
        rst = 1'b1; frame_tick = 1'b0; freeze = 1'b0; btn_raw = 4'b0000;
        wait_clks(3);
        check("rst_upd1",  int'(pif.upd1),  0);
        check("rst_upd2",  int'(pif.upd2),  0);
        check("rst_step1", int'(pif.step1), 0);
        check("rst_step2", int'(pif.step2), 0);
        check("rst_busy",  int'(pif.busy),  0);
        rst = 1'b0;

        // p1_up stable, one frame
        btn_raw = 4'b0001; wait_clks(10);
        do_frame(1);
        check("t1_n1", n1, 1);
        check("t1_at1", at1, 1);
        check("t1_dir1", d1, 0);
        check("t1_step1", s1, 1);
        check("t1_n2", n2, 0);
        check("t1_busy", b0, 1);
        check("t1_both", both, 0);

        // release: no motion
        btn_raw = 4'b0000; wait_clks(10);
        do_frame(1);
        check("rel_n1", n1, 0);

        // p1_down held across 5 frames: acceleration
        btn_raw = 4'b0010; wait_clks(10);
        for (int k = 0; k < 5; k++) begin
            do_frame(1);
            check("acc_n1", n1, 1);
            check("acc_dir1", d1, 1);
            check("acc_step1", s1, exp_down[k]);
        end

        // reverse while FAST: back to SLOW, hold restarts
        btn_raw = 4'b0001; wait_clks(10);
        for (int k = 0; k < 4; k++) begin
            do_frame(1);
            check("rev_dir1", d1, 0);
            check("rev_step1", s1, exp_up[k]);
        end

        // p2 up and down together: no motion
        btn_raw = 4'b1100; wait_clks(10);
        do_frame(1);
        check("conf_n2", n2, 0);
        check("conf_n1", n1, 0);
        // p2_up alone afterwards starts from IDLE at slow step
        btn_raw = 4'b0100; wait_clks(10);
        do_frame(1);
        check("p2_n2", n2, 1);
        check("p2_at2", at2, 2);
        check("p2_dir2", d2, 0);
        check("p2_step2", s2, 1);
        check("p2_n1", n1, 0);
        check("p2_both", both, 0);

        // 3-clock glitch is filtered out
        btn_raw = 4'b0000; wait_clks(10);
        do_frame(1);
        check("idle_n2", n2, 0);
        btn_raw = 4'b0001; wait_clks(3);
        btn_raw = 4'b0000; wait_clks(10);
        do_frame(1);
        check("glitch_n1", n1, 0);

        // two-clock tick: one sequence only
        btn_raw = 4'b0101; wait_clks(10);
        do_frame(2);
        check("dbl_n1", n1, 1);
        check("dbl_n2", n2, 1);
        check("dbl_both", both, 0);

        // accelerate P1 to FAST, then freeze and release
        do_frame(1); check("pre_step1a", s1, 1);
        do_frame(1); check("pre_step1b", s1, 1);
        do_frame(1); check("pre_step1c", s1, 4);
        freeze = 1'b1;
        do_frame(1);
        check("frz_n1", n1, 0);
        check("frz_n2", n2, 0);
        freeze = 1'b0;
        do_frame(1);
        check("unfrz_n1", n1, 1);
        check("unfrz_step1", s1, 1);
        check("unfrz_step2", s2, 1);

        // reset while in S_P1 aborts the sequence
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_upd1",  int'(pif.upd1),  0);
        check("mid_upd2",  int'(pif.upd2),  0);
        check("mid_step1", int'(pif.step1), 0);
        check("mid_step2", int'(pif.step2), 0);
        check("mid_busy",  int'(pif.busy),  0);
        rst = 1'b0;
        n1 = 0; n2 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pif.upd1) n1++;
            if (pif.upd2) n2++;
        end
        check("post_rst_n1", n1, 0);
        check("post_rst_n2", n2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
